// File: rtl/scramble_pkg.sv
// Shared types and constants for the line-rotation cut key schedule.
// Holds the scheduler state encoding, picture geometry and DRBG word sizes.
package scramble_pkg;

   localparam int ACTIVE_PIXELS = 720;
   localparam int CUT_W         = 10;
   localparam int DRBG_W        = 32;
   localparam int SEED_W        = 256;
   localparam int EPOCH_W       = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      ARMED  = 3'd2,
      FETCH  = 3'd3,
      STAGED = 3'd4
   } sched_state_e;

   // A 10-bit draw is below 2*ACTIVE_PIXELS, so one conditional subtract lands it in range.
   function automatic logic [CUT_W-1:0] fold_cut(input logic [CUT_W-1:0] raw,
                                                 input logic [CUT_W-1:0] limit);
      logic [CUT_W-1:0] res;
      if (raw >= limit) begin
         res = raw - limit;
      end else begin
         res = raw;
      end
      return res;
   endfunction

endpackage

// File: rtl/cut_key_scheduler_if.sv
// DRBG request/response bundle between the cut key scheduler (master) and the DRBG (slave).
interface cut_key_scheduler_if;
   import scramble_pkg::*;

   logic              drbg_init;
   logic [SEED_W-1:0] drbg_entropy;
   logic              drbg_init_ready;
   logic              drbg_next;
   logic              drbg_next_ready;
   logic [DRBG_W-1:0] drbg_bits;

   modport master (
      output drbg_init, drbg_entropy, drbg_next,
      input  drbg_init_ready, drbg_next_ready, drbg_bits
   );

   modport slave (
      input  drbg_init, drbg_entropy, drbg_next,
      output drbg_init_ready, drbg_next_ready, drbg_bits
   );

endinterface

// File: rtl/bt656_edge_detect.sv
// Registers the BT.656 H/V flags once and derives edge pulses from the registered
// value against its previous sample.
module bt656_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic h_i,
   input  logic v_i,
   output logic v_o,
   output logic h_rise_o,
   output logic h_fall_o,
   output logic v_rise_o,
   output logic v_fall_o
);

   logic h_q;
   logic h_prev_q;
   logic v_q;
   logic v_prev_q;

   // Two-deep history of each timing flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_q      <= 1'b0;
         h_prev_q <= 1'b0;
         v_q      <= 1'b0;
         v_prev_q <= 1'b0;
      end else begin
         h_q      <= h_i;
         h_prev_q <= h_q;
         v_q      <= v_i;
         v_prev_q <= v_q;
      end
   end

   assign v_o      = v_q;
   assign h_rise_o = h_q & ~h_prev_q;
   assign h_fall_o = ~h_q & h_prev_q;
   assign v_rise_o = v_q & ~v_prev_q;
   assign v_fall_o = ~v_q & v_prev_q;

endmodule

// File: rtl/cut_key_scheduler.sv
// Draws one DRBG word per active line and turns it into a cut position, handling
// seeding, periodic reseeds and late DRBG responses without losing keystream alignment.
module cut_key_scheduler
   import scramble_pkg::*;
#(
   parameter int ACTIVE_PIXELS = scramble_pkg::ACTIVE_PIXELS,
   parameter int RESEED_FIELDS = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [SEED_W-1:0]    seed,
   input  logic                 seed_load,
   input  logic                 H,
   input  logic                 V,
   cut_key_scheduler_if.master  drbg,
   output logic [CUT_W-1:0]     cut_position,
   output logic                 cut_valid,
   output logic                 underrun,
   output logic [EPOCH_W-1:0]   reseed_epoch
);

   localparam logic [CUT_W-1:0]   CUT_LIMIT   = CUT_W'(ACTIVE_PIXELS);
   localparam logic [EPOCH_W-1:0] RESEED_LAST = EPOCH_W'(RESEED_FIELDS - 1);

   logic v_q_s;
   logic h_rise_s;
   logic h_fall_s;
   logic v_rise_s;
   logic v_fall_s;

   bt656_edge_detect u_edges (
      .clk      (clk),
      .reset    (reset),
      .h_i      (H),
      .v_i      (V),
      .v_o      (v_q_s),
      .h_rise_o (h_rise_s),
      .h_fall_o (h_fall_s),
      .v_rise_o (v_rise_s),
      .v_fall_o (v_fall_s)
   );

   sched_state_e         state_q;
   logic [SEED_W-1:0]    seed_q;
   logic [EPOCH_W-1:0]   field_cnt_q;
   logic [EPOCH_W-1:0]   epoch_q;
   logic [CUT_W-1:0]     cut_next_q;
   logic [CUT_W-1:0]     cut_pos_q;
   logic                 cut_valid_q;
   logic                 underrun_q;
   logic                 init_q;
   logic [SEED_W-1:0]    entropy_q;
   logic                 next_q;
   logic                 init_out_q;
   logic                 next_out_q;
   logic                 init_issued_q;
   logic                 discard_q;
   logic                 reseed_pend_q;
   logic [CUT_W-1:0]     cut_fold_d;

   assign cut_fold_d = fold_cut(drbg.drbg_bits[CUT_W-1:0], CUT_LIMIT);

   // Key schedule FSM; all outputs are registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         seed_q        <= {SEED_W{1'b0}};
         field_cnt_q   <= 16'd0;
         epoch_q       <= 16'd0;
         cut_next_q    <= 10'd0;
         cut_pos_q     <= 10'd0;
         cut_valid_q   <= 1'b0;
         underrun_q    <= 1'b0;
         init_q        <= 1'b0;
         entropy_q     <= {SEED_W{1'b0}};
         next_q        <= 1'b0;
         init_out_q    <= 1'b0;
         next_out_q    <= 1'b0;
         init_issued_q <= 1'b0;
         discard_q     <= 1'b0;
         reseed_pend_q <= 1'b0;
      end else begin
         init_q     <= 1'b0;
         next_q     <= 1'b0;
         underrun_q <= 1'b0;
         if (drbg.drbg_init_ready) begin
            init_out_q <= 1'b0;
         end
         if (drbg.drbg_next_ready) begin
            next_out_q <= 1'b0;
         end

         if (seed_load) begin
            seed_q        <= seed;
            field_cnt_q   <= 16'd0;
            epoch_q       <= 16'd0;
            cut_valid_q   <= 1'b0;
            discard_q     <= 1'b0;
            reseed_pend_q <= 1'b0;
            init_issued_q <= 1'b0;
            state_q       <= INIT;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= IDLE;
               end
               INIT: begin
                  // Responses still in flight from before are drained before instantiating.
                  if (!init_issued_q) begin
                     if (!init_out_q && !next_out_q) begin
                        init_q        <= 1'b1;
                        entropy_q     <= {seed_q[SEED_W-1:EPOCH_W], seed_q[EPOCH_W-1:0] ^ epoch_q};
                        init_out_q    <= 1'b1;
                        init_issued_q <= 1'b1;
                        reseed_pend_q <= 1'b0;
                     end
                  end else if (!init_out_q) begin
                     init_issued_q <= 1'b0;
                     if (reseed_pend_q) begin
                        state_q <= INIT;
                     end else begin
                        state_q <= ARMED;
                     end
                  end
               end
               ARMED: begin
                  if (reseed_pend_q) begin
                     init_issued_q <= 1'b0;
                     state_q       <= INIT;
                  end else if (h_rise_s && !v_q_s) begin
                     next_q     <= 1'b1;
                     next_out_q <= 1'b1;
                     discard_q  <= 1'b0;
                     state_q    <= FETCH;
                  end
               end
               FETCH: begin
                  // A late word still counts as this line's draw; it is consumed and dropped.
                  if (h_fall_s && !discard_q) begin
                     underrun_q  <= 1'b1;
                     cut_pos_q   <= 10'd0;
                     cut_valid_q <= 1'b0;
                     if (drbg.drbg_next_ready) begin
                        state_q <= ARMED;
                     end else begin
                        discard_q <= 1'b1;
                     end
                  end else if (drbg.drbg_next_ready) begin
                     if (discard_q) begin
                        discard_q <= 1'b0;
                        state_q   <= ARMED;
                     end else begin
                        cut_next_q <= cut_fold_d;
                        state_q    <= STAGED;
                     end
                  end
               end
               STAGED: begin
                  if (h_fall_s) begin
                     cut_pos_q   <= cut_next_q;
                     cut_valid_q <= 1'b1;
                     state_q     <= ARMED;
                  end else if (reseed_pend_q) begin
                     init_issued_q <= 1'b0;
                     state_q       <= INIT;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase

            if (v_rise_s && (state_q != IDLE)) begin
               if (field_cnt_q == RESEED_LAST) begin
                  field_cnt_q   <= 16'd0;
                  epoch_q       <= epoch_q + 16'd1;
                  reseed_pend_q <= 1'b1;
               end else begin
                  field_cnt_q <= field_cnt_q + 16'd1;
               end
            end
            if (v_q_s) begin
               cut_valid_q <= 1'b0;
            end
         end
      end
   end

   logic unused_s;
   assign unused_s = ^{drbg.drbg_bits[DRBG_W-1:CUT_W], v_fall_s};

   assign drbg.drbg_init    = init_q;
   assign drbg.drbg_entropy = entropy_q;
   assign drbg.drbg_next    = next_q;
   assign cut_position      = cut_pos_q;
   assign cut_valid         = cut_valid_q;
   assign underrun          = underrun_q;
   assign reseed_epoch      = epoch_q;

endmodule

// File: doc/cut_key_scheduler.md
CUT_KEY_SCHEDULER -- requirements
Module: cut_key_scheduler

Interface
REQ-001 The block SHALL have parameter ACTIVE_PIXELS, default 720, giving the number of valid cut positions per active line.
REQ-002 The block SHALL have parameter RESEED_FIELDS, default 64, giving the number of fields between automatic DRBG reseeds.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  in  1  system clock, the only clock.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: seed  in  256  key material; sampled only on seed_load.
REQ-007 Port: seed_load  in  1  single-cycle pulse that latches seed and restarts the key schedule.
REQ-008 Ports: H, V  in  1 each  BT.656 timing flags from the stream decoder.
REQ-009 Ports: drbg_init  out  1  and drbg_entropy  out  256  carry the DRBG instantiate request.
REQ-010 Port: drbg_init_ready  in  1  DRBG instantiate complete.
REQ-011 Ports: drbg_next  out  1  requests one word; drbg_next_ready  in  1  and drbg_bits  in  32  return it.
REQ-012 Ports: cut_position  out  10  and cut_valid  out  1  carry the line-rotation cut for the current active line.
REQ-013 Ports: underrun  out  1  (single-cycle flag) and reseed_epoch  out  16  (count of reseeds since the last seed_load).

Function
REQ-014 H and V SHALL be registered once, and edges SHALL be detected from the registered value against its previous value, so every edge acts one cycle after the input changes.
REQ-015 States SHALL be IDLE, INIT, ARMED, FETCH and STAGED.
REQ-016 IDLE: all request outputs are low; seed_load moves the block to INIT.
REQ-017 INIT: drbg_init is high for exactly one cycle with drbg_entropy = {seed[255:16], seed[15:0] XOR reseed_epoch}; the block waits for drbg_init_ready and then enters ARMED.
REQ-018 ARMED: an H rising edge while registered V = 0 enters FETCH and pulses drbg_next for one cycle.
REQ-019 FETCH: on drbg_next_ready, cut_next = drbg_bits[9:0], minus ACTIVE_PIXELS if ≥ ACTIVE_PIXELS (one conditional subtract, 10-bit result); then the block enters STAGED.
REQ-020 STAGED: on an H falling edge, cut_position <= cut_next and cut_valid <= 1 on the following cycle, and the block returns to ARMED.
REQ-021 If an H falling edge occurs in FETCH, the block SHALL pulse underrun, set cut_position = 0 and cut_valid = 0, wait for the outstanding drbg_next_ready, discard that word, and return to ARMED.
REQ-022 Rule behind REQ-021: exactly one DRBG word is consumed per active line, so the scrambler and descrambler keystreams stay aligned.
REQ-023 While registered V = 1, no fetch SHALL start and cut_valid SHALL be 0.
REQ-024 A V rising edge SHALL increment the field counter; when the counter reaches RESEED_FIELDS, it clears to 0, reseed_epoch increments (wrapping at 16 bits), and the block enters INIT once any in-flight DRBG handshake has completed.
REQ-025 seed_load in any state SHALL take effect on the next cycle:
- seed is latched, the field counter and reseed_epoch are cleared, cut_valid is cleared;
- any in-flight DRBG response is discarded;
- the block enters INIT.
REQ-026 seed_load SHALL take priority over a simultaneous V or H edge.
REQ-027 drbg_init and drbg_next SHALL never be high in the same cycle, and neither SHALL be reissued before its ready is seen.

Reset
REQ-028 On reset, all outputs SHALL be 0, drbg_entropy SHALL be 0, the latched seed and all counters SHALL be 0, and the state SHALL be IDLE.
REQ-029 Reset asserted mid-handshake SHALL abandon the handshake; after release, no operation starts until seed_load.

Structure
REQ-030 A shared package scramble_pkg SHALL hold the state enum, ACTIVE_PIXELS, the cut width (10) and the DRBG word width (32).
REQ-031 Sub-module bt656_edge_detect SHALL register H and V and produce their rise and fall pulses; everything else is contained in cut_key_scheduler.

Verification
REQ-032 Scenario: reset, seed_load with seed = 0, DRBG model returns init_ready 3 cycles later -> exactly one drbg_init pulse with entropy 0, then ARMED.
REQ-033 Scenario: active line, drbg_bits = 0x000002FF (767) returned 5 cycles after H rises -> cut_position = 47 and cut_valid = 1 one cycle after H falls.
REQ-034 Scenario: drbg_bits = 0x00000100 -> cut_position = 256; drbg_bits[9:0] = 719 -> cut_position = 719 (boundary, no subtract).
REQ-035 Scenario: DRBG response delayed past H falling -> one underrun pulse, cut_valid = 0 for that line, late word discarded, next line uses the next word.
REQ-036 Scenario: RESEED_FIELDS = 2, three V rising edges -> drbg_init pulses after the second V rise with entropy[15:0] = seed[15:0] XOR 1, and reseed_epoch = 1.
REQ-037 Scenario: seed_load in the same cycle as an H edge during FETCH -> INIT entered, no underrun, cut_valid = 0, counters cleared.
